// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple-carry adder.
// Adds A + B + ci one bit per clock using a single full-adder cell and a
// carry flip-flop. A start/done handshake wraps the WIDTH-cycle operation;
// sum/co are registered and held until the next completion.
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Full-adder sum bit.
    function automatic logic fa_sum(input logic x, input logic y, input logic cin);
        return x ^ y ^ cin;
    endfunction

    // Full-adder carry-out bit.
    function automatic logic fa_carry(input logic x, input logic y, input logic cin);
        return (x & y) | (cin & (x ^ y));
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_c;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_co;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic             w_s;
    logic             w_c_nxt;
    logic             w_accept;
    logic             w_last;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // One full-adder cell working on the low bits of the operand shifters.
    assign w_s      = fa_sum(r_a_sr[0], r_b_sr[0], r_c);
    assign w_c_nxt  = fa_carry(r_a_sr[0], r_b_sr[0], r_c);
    // start is honoured only outside SHIFT; a request while busy is dropped.
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_cnt == LAST_CNT);

    // State register plus registered busy/done flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_SHIFT;
                else          w_state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
                if (w_last) w_state_nxt = ST_DONE;
                else        w_state_nxt = ST_SHIFT;
            end
            ST_DONE: begin
                if (w_accept) w_state_nxt = ST_SHIFT;
                else          w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the next state so busy/done come straight off flops.
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
            ST_SHIFT: begin
                w_busy_nxt = 1'b1;
                w_done_nxt = 1'b0;
            end
            ST_DONE: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Datapath: operand load, one bit per cycle, result capture on the last bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_c    <= 1'b0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_co   <= 1'b0;
        end else if (w_accept) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_c    <= ci;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_c    <= w_c_nxt;
            r_acc  <= {w_s, r_acc[WIDTH-1:1]};
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum <= {w_s, r_acc[WIDTH-1:1]};
                r_co  <= w_c_nxt;
            end else begin
                r_sum <= r_sum;
                r_co  <= r_co;
            end
        end else begin
            r_a_sr <= r_a_sr;
            r_b_sr <= r_b_sr;
            r_c    <= r_c;
            r_acc  <= r_acc;
            r_cnt  <= r_cnt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign co   = r_co;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a WIDTH=4 instance for the main
// directed steps and exhaustive sweep, and a WIDTH=8 instance for the wide case.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       ci4;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       co4;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       ci8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       co8;

    int checks;
    int errors;

    logic [4:0] q4[$];
    logic [8:0] q8[$];

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .ci    (ci4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .co    (co4)
    );

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .ci    (ci8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .co    (co8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("busy_done_excl4", {31'd0, busy4 & done4}, 32'd0);
        chk("busy_done_excl8", {31'd0, busy8 & done8}, 32'd0);
    endtask

    task automatic wait_done4(output int n);
        n = 0;
        while (done4 !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("done4_seen", {31'd0, done4}, 32'd1);
    endtask

    task automatic pop_cmp4(input string tag);
        logic [4:0] e;
        if (q4.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = q4.pop_front();
            chk(tag, {27'd0, co4, sum4}, {27'd0, e});
        end
    endtask

    // One full operation on the WIDTH=4 instance: start, latency check, result check.
    task automatic run_op4(input logic [3:0] av, input logic [3:0] bv, input logic cv, input string tag);
        int n;
        a4 = av; b4 = bv; ci4 = cv; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        q4.push_back(5'({1'b0, av}) + 5'({1'b0, bv}) + 5'({4'd0, cv}));
        wait_done4(n);
        chk({tag, "_lat"}, 32'(n), 32'd4);
        pop_cmp4(tag);
        tick();
    endtask

    initial begin
        int n;
        checks = 0; errors = 0;
        rst_n = 1'b0;
        start4 = 1'b0; a4 = 4'd0; b4 = 4'd0; ci4 = 1'b0;
        start8 = 1'b0; a8 = 8'd0; b8 = 8'd0; ci8 = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_busy", {31'd0, busy4}, 32'd0);
        chk("rst_done", {31'd0, done4}, 32'd0);
        chk("rst_sum",  {28'd0, sum4}, 32'd0);
        chk("rst_co",   {31'd0, co4}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: basic add, busy for 4 cycles then a done pulse
        a4 = 4'h3; b4 = 4'h5; ci4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        q4.push_back(5'h08);
        for (int i = 0; i < 4; i++) begin
            chk("t1_busy", {31'd0, busy4}, 32'd1);
            chk("t1_nodone", {31'd0, done4}, 32'd0);
            tick();
        end
        chk("t1_done", {31'd0, done4}, 32'd1);
        chk("t1_busy_low", {31'd0, busy4}, 32'd0);
        pop_cmp4("t1_result");
        tick();
        chk("t1_done_pulse", {31'd0, done4}, 32'd0);
        chk("t1_sum_held", {28'd0, sum4}, 32'h8);

        // 2: carry and wrap, then exhaustive sweep
        run_op4(4'hF, 4'h1, 1'b0, "t2_f_1");
        chk("t2a_sum", {28'd0, sum4}, 32'h0);
        chk("t2a_co", {31'd0, co4}, 32'd1);
        run_op4(4'hF, 4'hF, 1'b1, "t2_f_f_1");
        chk("t2b_sum", {28'd0, sum4}, 32'hF);
        chk("t2b_co", {31'd0, co4}, 32'd1);
        for (int x = 0; x < 512; x++) begin
            run_op4(4'(x >> 5), 4'(x >> 1), x[0], "t2_sweep");
        end

        // 3: start while busy is ignored
        a4 = 4'd2; b4 = 4'd2; ci4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        q4.push_back(5'h04);
        tick();
        a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4(n);
        chk("t3_lat", 32'(n + 2), 32'd4);
        pop_cmp4("t3_result");
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t3_no_second_done", {31'd0, done4}, 32'd0);
        end
        chk("t3_sb_empty", 32'(q4.size()), 32'd0);

        // 4: back-to-back with start held high
        a4 = 4'd1; b4 = 4'd1; ci4 = 1'b0; start4 = 1'b1;
        tick();
        q4.push_back(5'd2);
        wait_done4(n);
        chk("t4_first_lat", 32'(n), 32'd4);
        a4 = 4'd6; b4 = 4'd3;
        q4.push_back(5'd9);
        pop_cmp4("t4_first");
        tick();
        start4 = 1'b0;
        chk("t4_no_idle", {31'd0, busy4}, 32'd1);
        wait_done4(n);
        chk("t4_second_lat", 32'(n + 1), 32'd5);
        pop_cmp4("t4_second");
        tick();

        // 5: reset in the middle of SHIFT discards the partial result
        run_op4(4'h3, 4'h5, 1'b0, "t5_prior");
        chk("t5_prior_sum", {28'd0, sum4}, 32'h8);
        a4 = 4'h9; b4 = 4'h9; ci4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_busy", {31'd0, busy4}, 32'd0);
        chk("t5_done", {31'd0, done4}, 32'd0);
        chk("t5_sum", {28'd0, sum4}, 32'h0);
        chk("t5_co", {31'd0, co4}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5_no_done", {31'd0, done4}, 32'd0);
            chk("t5_sum_zero", {28'd0, sum4}, 32'h0);
        end

        // 6: WIDTH=8 instance
        a8 = 8'hC8; b8 = 8'h64; ci8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        q8.push_back(9'({1'b0, a8}) + 9'({1'b0, b8}) + 9'({8'd0, ci8}));
        n = 0;
        while (done8 !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        chk("t6_done_seen", {31'd0, done8}, 32'd1);
        chk("t6_lat", 32'(n), 32'd8);
        if (q8.size() == 0) begin
            chk("t6_sb_empty", 32'd0, 32'd1);
        end else begin
            chk("t6_result", {23'd0, co8, sum8}, {23'd0, q8.pop_front()});
        end
        chk("t6_sum_const", {24'd0, sum8}, 32'h2D);
        chk("t6_co_const", {31'd0, co8}, 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
